// File: rtl/seg7_scan_bcd.sv
// seg7_scan_bcd: multiplexed NDIG-digit 7-segment driver showing a loaded value in hex or in decimal
// (sequential double-dabble). Define SEG7_DP_EN to add the dp_in/dp decimal-point path.
module seg7_scan_bcd #(
  parameter int NDIG     = 4,
  parameter int DW       = 8,
  parameter int SCAN_DIV = 65536
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [DW-1:0]   x,
  input  logic            load,
  input  logic            mode,
  input  logic            blank_lz,
`ifdef SEG7_DP_EN
  input  logic [NDIG-1:0] dp_in,
  output logic            dp,
`endif
  output logic            busy,
  output logic            ovf,
  output logic [NDIG-1:0] an,
  output logic [6:0]      a_to_g
);

  localparam int BW = 4 * NDIG;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(DW + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   acc_adj;
  logic            of_q, of_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   disp_q, disp_d;
  logic            ovf_q, ovf_d;

  logic [PW-1:0]   pre_q, pre_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            tick;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      nib;
  logic            blank;
  logic            upper_zero;
`ifdef SEG7_DP_EN
  logic            dp_q, dp_d;
  logic            dp_sel;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Loads are only honoured in IDLE; ovf keeps its value across a decimal conversion until DONE commits.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    of_d    = of_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    acc_adj = acc_q;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (mode) begin
            state_d = SHIFT;
            sr_d    = x;
            acc_d   = '0;
            of_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            disp_d = BW'(x);
            ovf_d  = 1'b0;
          end
        end
      end
      SHIFT: begin
        acc_d = {acc_adj[BW-2:0], sr_q[DW-1]};
        sr_d  = sr_q << 1;
        of_d  = of_q | acc_adj[BW-1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        disp_d  = acc_q;
        ovf_d   = of_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sr_q   <= '0;
      acc_q  <= '0;
      of_q   <= 1'b0;
      cnt_q  <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      of_q   <= of_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // Walk digits from the top so upper_zero reflects "this digit and every higher one is zero".
  always_comb begin
    nib        = 4'd0;
    blank      = 1'b0;
    upper_zero = 1'b1;
`ifdef SEG7_DP_EN
    dp_sel     = 1'b0;
`endif
    for (int i = NDIG - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        nib   = disp_q[4*i +: 4];
        blank = blank_lz & upper_zero & (i != 0);
`ifdef SEG7_DP_EN
        dp_sel = dp_in[i];
`endif
      end
    end
    an_d = ~(NDIG'(1) << idx_q);
    if (ovf_q)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = seg_decode(nib);
`ifdef SEG7_DP_EN
    dp_d = ovf_q | ~dp_sel;
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
`ifdef SEG7_DP_EN
      dp_q  <= 1'b1;
`endif
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
`ifdef SEG7_DP_EN
      dp_q  <= dp_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign ovf    = ovf_q;
  assign an     = an_q;
  assign a_to_g = seg_q;
`ifdef SEG7_DP_EN
  assign dp     = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Bench for seg7_scan_bcd: a 4-digit and a 2-digit instance share stimulus and are compared each
// cycle against a digit-arithmetic reference model. Checks dp when SEG7_DP_EN is defined.
module tb_seg7_scan_bcd;

  localparam int DW = 8;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          clr, load, mode, blank_lz;
  logic [DW-1:0] x;
  logic          busy0, ovf0, busy1, ovf1;
  logic [3:0]    an0;
  logic [1:0]    an1;
  logic [6:0]    seg0, seg1;
`ifdef SEG7_DP_EN
  logic [3:0]    dp_in;
  logic          dp0, dp1;
  logic          e_dp [2];
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   nd     [2] = '{4, 2};
  int   val    [2];
  int   radix  [2];
  int   cnt    [2];
  int   pend   [2];
  logic ovfm   [2];
  logic [7:0] e_an [2];
  logic [6:0] e_seg [2];
  logic e_busy [2];
  logic e_ovf  [2];

  always #5 clk = ~clk;

  seg7_scan_bcd #(.NDIG(4), .DW(DW), .SCAN_DIV(S)) u_dut0 (
    .clk(clk), .clr(clr), .x(x), .load(load), .mode(mode), .blank_lz(blank_lz),
`ifdef SEG7_DP_EN
    .dp_in(dp_in), .dp(dp0),
`endif
    .busy(busy0), .ovf(ovf0), .an(an0), .a_to_g(seg0)
  );

  seg7_scan_bcd #(.NDIG(2), .DW(DW), .SCAN_DIV(S)) u_dut1 (
    .clk(clk), .clr(clr), .x(x), .load(load), .mode(mode), .blank_lz(blank_lz),
`ifdef SEG7_DP_EN
    .dp_in(dp_in[1:0]), .dp(dp1),
`endif
    .busy(busy1), .ovf(ovf1), .an(an1), .a_to_g(seg1)
  );

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      15: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkBits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkBits("an0",   {4'b0, an0},      e_an[0]);
    checkBits("seg0",  {1'b0, seg0},     {1'b0, e_seg[0]});
    checkBits("busy0", {7'b0, busy0},    {7'b0, e_busy[0]});
    checkBits("ovf0",  {7'b0, ovf0},     {7'b0, e_ovf[0]});
    checkBits("an1",   {6'b0, an1},      e_an[1]);
    checkBits("seg1",  {1'b0, seg1},     {1'b0, e_seg[1]});
    checkBits("busy1", {7'b0, busy1},    {7'b0, e_busy[1]});
    checkBits("ovf1",  {7'b0, ovf1},     {7'b0, e_ovf[1]});
`ifdef SEG7_DP_EN
    checkBits("dp0",   {7'b0, dp0},      {7'b0, e_dp[0]});
    checkBits("dp1",   {7'b0, dp1},      {7'b0, e_dp[1]});
`endif
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      val[k]    = 0;
      radix[k]  = 16;
      cnt[k]    = 0;
      pend[k]   = 0;
      ovfm[k]   = 1'b0;
      e_an[k]   = 8'(ipow(2, nd[k]) - 1);
      e_seg[k]  = 7'b1111111;
      e_busy[k] = 1'b0;
      e_ovf[k]  = 1'b0;
`ifdef SEG7_DP_EN
      e_dp[k]   = 1'b1;
`endif
    end
  endtask

  // Outputs on an edge reflect the value shown before it; the load takes effect afterwards.
  task automatic model_edge(input logic ld, input logic md, input logic [DW-1:0] xv, input logic bl
`ifdef SEG7_DP_EN
                            , input logic [3:0] dv
`endif
                            );
    int idx, v, p;
    for (int k = 0; k < 2; k++) begin
      idx      = (cyc / S) % nd[k];
      e_an[k]  = 8'((ipow(2, nd[k]) - 1) ^ (1 << idx));
      if (ovfm[k]) begin
        e_seg[k] = 7'b1111110;
      end else begin
        v = val[k] % ipow(radix[k], nd[k]);
        p = ipow(radix[k], idx);
        if (bl && idx > 0 && (v / p) == 0) e_seg[k] = 7'b1111111;
        else                               e_seg[k] = seg_of((v / p) % radix[k]);
      end
`ifdef SEG7_DP_EN
      e_dp[k] = ovfm[k] ? 1'b1 : ~dv[idx];
`endif
      if (cnt[k] == 0 && ld) begin
        if (!md) begin
          val[k]   = int'(xv);
          radix[k] = 16;
          ovfm[k]  = 1'b0;
        end else begin
          pend[k] = int'(xv);
          cnt[k]  = DW + 1;
        end
      end else if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          if (pend[k] >= ipow(10, nd[k])) begin
            ovfm[k] = 1'b1;
          end else begin
            ovfm[k]  = 1'b0;
            val[k]   = pend[k];
            radix[k] = 10;
          end
        end
      end
      e_busy[k] = (cnt[k] > 0);
      e_ovf[k]  = ovfm[k];
    end
    cyc++;
  endtask

  task automatic step();
    logic ld, md, bl, rs;
    logic [DW-1:0] xv;
`ifdef SEG7_DP_EN
    logic [3:0] dv;
    dv = dp_in;
`endif
    ld = load; md = mode; bl = blank_lz; rs = clr; xv = x;
    @(posedge clk);
    #1;
`ifdef SEG7_DP_EN
    if (rs) model_edge(ld, md, xv, bl, dv);
`else
    if (rs) model_edge(ld, md, xv, bl);
`endif
    checkOutput();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic doReset();
    clr = 1'b0;
    #1;
    model_reset();
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [DW-1:0] xv, input logic md);
    x    = xv;
    mode = md;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; x = '0;
`ifdef SEG7_DP_EN
    dp_in = 4'b0010;
`endif
    model_reset();
    #2;
    doReset();
    run(2);
    clr = 1'b1;
    run(2 * 4 * S + 3);

    $display("[TB] mid-scan reset");
    doReset();
    run(1);
    clr = 1'b1;
    run(4 * S + 2);

    $display("[TB] hex load 8'hA5");
    applyStimulus(8'hA5, 1'b0);
    run(4 * S + 2);
    blank_lz = 1'b1;
    run(4 * S + 2);
    blank_lz = 1'b0;

    $display("[TB] decimal load 255");
    applyStimulus(8'd255, 1'b1);
    run(DW + 4 * S + 4);
    blank_lz = 1'b1;
    run(4 * S + 2);

    $display("[TB] decimal load 100 then hex 0F");
    applyStimulus(8'd100, 1'b1);
    run(DW + 4 * S + 4);
    applyStimulus(8'h0F, 1'b0);
    run(4 * S + 2);
    blank_lz = 1'b0;
    run(4 * S + 2);

    $display("[TB] loads during SHIFT and DONE are ignored");
    applyStimulus(8'd255, 1'b1);
    run(2);
    applyStimulus(8'd7, 1'b1);
    run(5);
    applyStimulus(8'd3, 1'b0);
    run(4 * S + 4);

    $display("[TB] reset during SHIFT");
    applyStimulus(8'd200, 1'b1);
    run(3);
    doReset();
    run(1);
    clr = 1'b1;
    run(4 * S + 2);

    $display("[TB] randomized phase");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        x    = DW'($urandom);
        mode = 1'($urandom_range(0, 1));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
`ifdef SEG7_DP_EN
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
`endif
      if (n == 300) begin
        load = 1'b0;
        doReset();
        run(1);
        clr = 1'b1;
      end
      step();
    end
    load = 1'b0;
    run(4 * S);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
